// File: rtl/risc_cpu_core.sv
// risc_cpu_core: parametrised single-accumulator RISC core with a req/ack
// memory bus (wait states allowed), a resumable HALT state and exported
// architectural state.
//
// Instruction word: opcode = ir[DATA_W-1 -: 3], operand = ir[ADDR_W-1:0].
// Requires DATA_W >= ADDR_W + 3.
//
// Ports:
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   mem_req/mem_we     bus request and direction (1 = write)
//   mem_addr/mem_wdata transaction address and write data
//   mem_rdata/mem_ack  read data and completion strobe from memory
//   resume             leave the HALT state
//   halted             core is in HALT
//   pc, acc            program counter and accumulator
module risc_cpu_core #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  input  logic              resume,
  output logic              halted,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] acc
);

  typedef enum logic [2:0] {FETCH, DECODE, READ, WRITE, HALT} state_t;
  typedef enum logic [2:0] {
    OP_HLT, OP_SKZ, OP_ADD, OP_AND, OP_XOR, OP_LDA, OP_STO, OP_JMP
  } opcode_t;

  state_t            state;
  state_t            state_nxt;
  logic [DATA_W-1:0] ir;
  opcode_t           opcode;
  logic [ADDR_W-1:0] operand;
  logic              zero;
  logic              mem_done;
  logic              unused_ir;

  assign opcode    = opcode_t'(ir[DATA_W-1 -: 3]);
  assign operand   = ir[ADDR_W-1:0];
  // Bits between the opcode and operand fields carry no meaning.
  assign unused_ir = ^ir;
  assign zero      = (acc == '0);
  // An ack only completes a transaction while a request is being made.
  assign mem_done  = mem_req & mem_ack;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      FETCH: begin
        if (mem_done) state_nxt = DECODE;
      end
      DECODE: begin
        case (opcode)
          OP_HLT:         state_nxt = HALT;
          OP_SKZ, OP_JMP: state_nxt = FETCH;
          OP_STO:         state_nxt = WRITE;
          default:        state_nxt = READ;
        endcase
      end
      READ, WRITE: begin
        if (mem_done) state_nxt = FETCH;
      end
      HALT: begin
        if (resume) state_nxt = FETCH;
      end
      default: state_nxt = FETCH;
    endcase
  end

  // Moore-decoded bus and status outputs
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = pc;
    mem_wdata = '0;
    halted    = 1'b0;
    case (state)
      FETCH: begin
        mem_req  = 1'b1;
        mem_addr = pc;
      end
      READ: begin
        mem_req  = 1'b1;
        mem_addr = operand;
      end
      WRITE: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = operand;
        mem_wdata = acc;
      end
      HALT: halted = 1'b1;
      default: ;
    endcase
    // The reset state is FETCH, so the request is masked while reset is held
    // to abandon any in-flight transaction immediately.
    if (!rst_n) mem_req = 1'b0;
  end

  // Architectural registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc  <= ADDR_W'(RESET_PC);
      acc <= '0;
      ir  <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (mem_done) begin
            ir <= mem_rdata;
            pc <= pc + ADDR_W'(1);
          end
        end
        DECODE: begin
          if (opcode == OP_SKZ && zero) begin
            pc <= pc + ADDR_W'(1);
          end else if (opcode == OP_JMP) begin
            pc <= operand;
          end
        end
        READ: begin
          if (mem_done) begin
            case (opcode)
              OP_ADD:  acc <= acc + mem_rdata;
              OP_AND:  acc <= acc & mem_rdata;
              OP_XOR:  acc <= acc ^ mem_rdata;
              OP_LDA:  acc <= mem_rdata;
              default: acc <= acc;
            endcase
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/risc_cpu_core.md
Name: risc_cpu_core

Overview:
- Parametrised accumulator-based RISC core; next generation of the 8-bit single-accumulator CPU.
- Generalised data and address widths.
- Replaces fixed-timing internal memory strobes with a req/ack memory bus that supports wait states.
- Adds a resumable halt state and exports architectural state (pc, acc) for debug and verification.

Parameters:
- DATA_W, 8: accumulator, instruction and memory word width. Must satisfy DATA_W >= ADDR_W+3.
- ADDR_W, 5: address width; memory depth is 2^ADDR_W words.
- RESET_PC, 0: pc value loaded on reset.

Ports:
- clk  in  1: single clock, rising edge.
- rst_n  in  1: asynchronous active-low reset.
- mem_req  out  1: memory transaction request.
- mem_we  out  1: 1 = write, 0 = read; valid while mem_req=1.
- mem_addr  out  ADDR_W: transaction address.
- mem_wdata  out  DATA_W: write data; valid while mem_req=1 and mem_we=1.
- mem_rdata  in  DATA_W: read data; sampled on the ack cycle.
- mem_ack  in  1: transaction complete this cycle.
- resume  in  1: leave HALT state.
- halted  out  1: core is in HALT state.
- pc  out  ADDR_W: program counter.
- acc  out  DATA_W: accumulator.

Behaviour:
- Reset (async, rst_n=0):
  - state=FETCH, pc=RESET_PC, acc=0, ir=0, halted=0.
  - mem_req=0 while rst_n=0.
  - A transaction in flight when reset asserts is abandoned; memory must tolerate the abort.
- Instruction format:
  - opcode = ir[DATA_W-1:DATA_W-3].
  - operand address = ir[ADDR_W-1:0]; any bits in between are ignored.
- Opcodes: 0 HLT, 1 SKZ, 2 ADD, 3 AND, 4 XOR, 5 LDA, 6 STO, 7 JMP.
- zero = (acc == 0), evaluated combinationally from the current acc.
- Memory bus outputs are Moore-decoded from state:
  - mem_req=1 in FETCH, READ and WRITE only.
  - A transaction completes on the first rising edge with mem_req=1 and mem_ack=1; zero-wait ack in the same cycle is legal.
  - Outputs stay stable until ack.
  - mem_ack with mem_req=0 is ignored.
- FSM:
  - FETCH: mem_addr=pc, mem_we=0. On ack: ir<=mem_rdata, pc<=pc+1 (wraps modulo 2^ADDR_W), go to DECODE.
  - DECODE (1 cycle, no request):
    - HLT -> HALT.
    - SKZ: if zero, pc<=pc+1 (wraps); -> FETCH.
    - JMP: pc<=operand; -> FETCH.
    - ADD/AND/XOR/LDA -> READ.
    - STO -> WRITE.
  - READ: mem_addr=operand, mem_we=0. On ack: acc<= acc+rdata (ADD, carry discarded, wraps modulo 2^DATA_W), acc&rdata (AND), acc^rdata (XOR), rdata (LDA); -> FETCH.
  - WRITE: mem_addr=operand, mem_we=1, mem_wdata=acc. On ack -> FETCH; acc unchanged.
  - HALT: halted=1, no requests. When resume=1 -> FETCH; pc already points past the HLT. resume outside HALT is ignored.
- Latency with zero-wait memory:
  - HLT, SKZ, JMP: 2 cycles.
  - ADD, AND, XOR, LDA, STO: 3 cycles.
  - Each wait cycle adds one cycle.
- The acc and zero used by SKZ in DECODE include the result of the immediately preceding instruction.
- pc wraps from 2^ADDR_W-1 to 0 on both fetch increment and skip increment.

Test Plan:
- Reset and first fetch, defaults, zero-wait memory: mem[0]=LDA 10, mem[10]=0x5A -> mem_req=1 at mem_addr=0 in the first cycle after reset; after 3 cycles acc=0x5A, pc=1.
- Arithmetic and store, mem[11]=0xF0: ADD 11 -> acc=0x4A (carry dropped); XOR 11 -> acc=0xBA; STO 12 -> write cycle with mem_we=1, addr=12, wdata=0xBA.
- SKZ and JMP: with acc=0, SKZ at pc=4 -> next fetch addr=6. With acc≠0 -> next fetch addr=5. JMP 20 -> next fetch addr=20.
- Wait states: random 0-5 cycle ack delays on every transaction -> final acc, pc and memory image identical to the zero-wait run; mem_addr, mem_we and mem_wdata stable while mem_req=1 and mem_ack=0.
- Halt/resume: HLT at addr 7 -> halted=1, no mem_req for 50 cycles; resume pulse -> halted=0, next fetch addr=8. resume asserted while running has no effect.
- Reset mid-READ (ack withheld) and pc wrap: rst_n low mid-READ -> mem_req=0 immediately; after release, fetch from RESET_PC with acc=0. With ADDR_W=5, instruction at 31 -> next fetch addr=0. Rerun the scenarios with DATA_W=16, ADDR_W=8 -> equivalent results.
